mux_to_leds: RTL and testbench

//   Drives an N-bit LED bank from a single select input. i_sel=0 shows a

---
 rtl/mux_to_leds_pkg.sv | 15 +
 rtl/mux_to_leds_if.sv | 10 +
 rtl/mux_to_leds_walker.sv | 49 ++++
 rtl/mux_to_leds.sv | 48 ++++
 tb/tb_mux_to_leds.sv | 122 ++++++++++++
 5 files changed

// File: rtl/mux_to_leds_pkg.sv
// Shared constants and helpers for the LED select block.
package mux_to_leds_pkg;
  localparam logic SEL_STATIC = 1'b0;
  localparam logic SEL_WALK   = 1'b1;
  localparam int   MAX_N      = 64;

  // Repeating ...0101 pattern, bit0 set, truncated to n bits.
  function automatic logic [MAX_N-1:0] default_pattern(input int n);
    logic [MAX_N-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_N; i += 2)
      if (i < n) p[i] = 1'b1;
    return p;
  endfunction
endpackage

// File: rtl/mux_to_leds_if.sv
// Board-side select input and LED drive bundle.
interface mux_to_leds_if #(
  parameter int N = 4
) ();
  logic         i_sel;
  logic [N-1:0] o_y;

  modport master (output i_sel, input o_y);
  modport slave  (input i_sel, output o_y);
endinterface

// File: rtl/mux_to_leds_walker.sv
// Divider plus rotating one-hot register; steps once every DIV_CYCLES clocks.
module led_walker #(
  parameter int N          = 4,
  parameter int DIV_CYCLES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_restart,
  output logic [N-1:0] o_pattern
);
  localparam int            DW       = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_CYCLES - 1);

  logic [DW-1:0] div_q, div_d;
  logic [N-1:0]  walk_q, walk_d, walk_rot;

  generate
    if (N == 1) begin : g_rot1
      assign walk_rot = walk_q;
    end else begin : g_rotn
      assign walk_rot = {walk_q[N-2:0], walk_q[N-1]};
    end
  endgenerate

  always_comb begin
    div_d  = '0;
    walk_d = walk_q;
    if (i_restart) begin
      walk_d = N'(1);
    end else if (i_en) begin
      if (div_q == DIV_LAST) walk_d = walk_rot;
      else                   div_d  = div_q + DW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_q  <= '0;
      walk_q <= N'(1);
    end else begin
      div_q  <= div_d;
      walk_q <= walk_d;
    end
  end

  // Next-state view so the registered LED output lines up with the walker step.
  assign o_pattern = walk_d;
endmodule

// File: rtl/mux_to_leds.sv
// LED bank driver: static pattern or walking one, chosen by a synchronized switch.
module mux_to_leds
  import mux_to_leds_pkg::*;
#(
  parameter int           N           = 4,
  parameter logic [N-1:0] PATTERN_A   = N'(default_pattern(N)),
  parameter int           DIV_CYCLES  = 4,
  parameter int           SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mux_to_leds_if.slave  bus
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sel_s, sel_d_q, restart;
  logic [N-1:0]           walk_pat, y_d, y_q;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], bus.i_sel};
  assign sel_s   = sync_q[SYNC_STAGES-1];
  assign restart = sel_s & ~sel_d_q;

  led_walker #(
    .N          (N),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_walker (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (sel_s),
    .i_restart (restart),
    .o_pattern (walk_pat)
  );

  assign y_d = (sel_s == SEL_STATIC) ? PATTERN_A : walk_pat;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      sel_d_q <= 1'b0;
      y_q     <= '0;
    end else begin
      sync_q  <= sync_d;
      sel_d_q <= sel_s;
      y_q     <= y_d;
    end
  end

  assign bus.o_y = y_q;
endmodule

// File: tb/tb_mux_to_leds.sv
// Directed scoreboard bench: N=4/DIV=4, N=1/DIV=1 and N=5/DIV=1 instances.
module tb_mux_to_leds;
  logic clk = 1'b0;
  logic rst_n;
  logic sel;

  always #5 clk = ~clk;

  mux_to_leds_if #(.N(4)) bus4 ();
  mux_to_leds_if #(.N(1)) bus1 ();
  mux_to_leds_if #(.N(5)) bus5 ();
  assign bus4.i_sel = sel;
  assign bus1.i_sel = sel;
  assign bus5.i_sel = sel;

  mux_to_leds #(.N(4), .DIV_CYCLES(4), .SYNC_STAGES(2)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus4));
  mux_to_leds #(.N(1), .PATTERN_A(1'b0), .DIV_CYCLES(1), .SYNC_STAGES(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
  mux_to_leds #(.N(5), .DIV_CYCLES(1), .SYNC_STAGES(2)) u_dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus5));

  typedef struct {
    string      nm;
    logic       c4;
    logic [3:0] e4;
    logic       c1;
    logic       e1;
    logic       c5;
    logic [4:0] e5;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: o_y=%b expected %b", nm, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per rising edge, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.c4) chk({e.nm, "_n4"}, {1'b0, bus4.o_y}, {1'b0, e.e4});
        if (e.c1) chk({e.nm, "_n1"}, {4'b0, bus1.o_y}, {4'b0, e.e1});
        if (e.c5) chk({e.nm, "_n5"}, bus5.o_y, e.e5);
      end
    end
  end

  task automatic step4(input logic r, input logic s, input logic c,
                       input logic [3:0] e, input string nm);
    exp_t x;
    rst_n = r; sel = s;
    x.nm = nm; x.c4 = c; x.e4 = e; x.c1 = 1'b0; x.e1 = 1'b0; x.c5 = 1'b0; x.e5 = '0;
    sb.push_back(x);
    @(posedge clk); #2;
  endtask

  task automatic step15(input logic r, input logic s, input logic e1,
                        input logic [4:0] e5, input string nm);
    exp_t x;
    rst_n = r; sel = s;
    x.nm = nm; x.c4 = 1'b0; x.e4 = '0; x.c1 = 1'b1; x.e1 = e1; x.c5 = 1'b1; x.e5 = e5;
    sb.push_back(x);
    @(posedge clk); #2;
  endtask

  logic [3:0] t4_exp [19] = '{4'b0010, 4'b0010, 4'b0101, 4'b0001, 4'b0101, 4'b0001,
                              4'b0101, 4'b0001, 4'b0101, 4'b0001, 4'b0001, 4'b0001,
                              4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                              4'b0100};
  logic [3:0] t5_exp [7]  = '{4'b0101, 4'b0101, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                              4'b0010};
  logic [4:0] t6_w5  [6]  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

  initial begin
    rst_n = 1'b0;
    sel   = 1'b1;

    repeat (3) step4(1'b0, 1'b1, 1'b1, 4'b0000, "reset_hold");

    for (int i = 0; i < 6; i++) step4(1'b1, 1'b0, i >= 2, 4'b0101, "static");

    for (int k = 0; k < 22; k++)
      step4(1'b1, 1'b1, 1'b1, (k < 2) ? 4'b0101 : 4'(1 << (((k - 2) / 4) % 4)), "walk");

    for (int i = 0; i < 19; i++) begin
      logic s;
      s = (i < 8) ? i[0] : 1'b1;
      step4(1'b1, s, 1'b1, t4_exp[i], "toggle");
    end

    repeat (2) step4(1'b0, 1'b1, 1'b1, 4'b0000, "rst_mid");
    for (int i = 0; i < 7; i++) step4(1'b1, 1'b1, 1'b1, t5_exp[i], "rst_reentry");

    step15(1'b0, 1'b0, 1'b0, 5'b00000, "sweep_rst");
    repeat (3) step15(1'b1, 1'b0, 1'b0, 5'b10101, "sweep_static");
    repeat (2) step15(1'b1, 1'b1, 1'b0, 5'b10101, "sweep_lat");
    for (int i = 0; i < 6; i++) step15(1'b1, 1'b1, 1'b1, t6_w5[i], "sweep_walk");
    step15(1'b1, 1'b0, 1'b1, 5'b00010, "sweep_tail");
    step15(1'b1, 1'b0, 1'b1, 5'b00100, "sweep_tail");
    repeat (2) step15(1'b1, 1'b0, 1'b0, 5'b10101, "sweep_back");

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
